// File: rtl/execute_simd_if.sv
// Handshake and data bundle between decode, the SIMD execute stage and memory.
interface execute_simd_if #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned LANE_W = 16,
  parameter int unsigned PC_W   = 15
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*LANE_W-1:0]   rd1;
  logic [LANES*LANE_W-1:0]   rd2;
  logic [2:0]                alu_control;
  logic                      add1_sel;
  logic                      mem_sel;
  logic [PC_W-1:0]           pc_8;
  logic [PC_W-1:0]           branch;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*LANE_W-1:0]   alu_out;
  logic [PC_W-1:0]           add_8_out;
  logic [LANES-1:0]          lane_zero;
  logic                      zero_flag;

  modport slave (
    input  in_valid, rd1, rd2, alu_control, add1_sel, mem_sel, pc_8, branch, out_ready,
    output in_ready, out_valid, alu_out, add_8_out, lane_zero, zero_flag
  );

  modport master (
    output in_valid, rd1, rd2, alu_control, add1_sel, mem_sel, pc_8, branch, out_ready,
    input  in_ready, out_valid, alu_out, add_8_out, lane_zero, zero_flag
  );
endinterface

// File: rtl/execute_simd.sv
// Lane-wise SIMD execute stage with iterative shift-add multiply, branch
// target adder and a one-entry registered result behind valid/ready.
module execute_simd #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned LANE_W = 16,
  parameter int unsigned PC_W   = 15
) (
  input  logic          clk,
  input  logic          rst,
  execute_simd_if.slave bus
);
  localparam int unsigned W     = LANES * LANE_W;
  localparam int unsigned CNT_W = $clog2(LANE_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FULL} state_e;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_MUL  = 3'b101,
    OP_MIN  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [LANE_W-1:0] acc_q    [LANES];
  logic [LANE_W-1:0] mcand_q  [LANES];
  logic [LANE_W-1:0] mplier_q [LANES];
  logic [LANE_W-1:0] acc_nxt  [LANES];
  logic [LANE_W-1:0] a_lane   [LANES];
  logic [LANE_W-1:0] b_lane   [LANES];
  logic [W-1:0]      alu_res;
  logic [W-1:0]      prod;
  logic [W-1:0]      res_sel;
  logic [W-1:0]      alu_out_q;
  logic [LANES-1:0]  lz_d, lz_q;
  logic              zf_q;
  logic [PC_W-1:0]   br_sum, add8_q, add8_pend_q;
  logic              in_ready_c, accept, is_mul, mul_done;

  assign in_ready_c = (state_q == S_IDLE) || ((state_q == S_FULL) && bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;
  assign is_mul     = (op_e'(bus.alu_control) == OP_MUL);
  assign mul_done   = (state_q == S_MUL) && (cnt_q == CNT_W'(1));
  assign br_sum     = bus.pc_8 + bus.branch;

  // B-operand select and single-cycle lane ALU
  always_comb begin
    alu_res = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      a_lane[i] = bus.rd1[i*LANE_W +: LANE_W];
      if (bus.mem_sel)
        b_lane[i] = '0;
      else if (bus.add1_sel)
        b_lane[i] = LANE_W'(1);
      else
        b_lane[i] = bus.rd2[i*LANE_W +: LANE_W];
      case (op_e'(bus.alu_control))
        OP_ADD:  alu_res[i*LANE_W +: LANE_W] = a_lane[i] + b_lane[i];
        OP_SUB:  alu_res[i*LANE_W +: LANE_W] = a_lane[i] - b_lane[i];
        OP_AND:  alu_res[i*LANE_W +: LANE_W] = a_lane[i] & b_lane[i];
        OP_OR:   alu_res[i*LANE_W +: LANE_W] = a_lane[i] | b_lane[i];
        OP_XOR:  alu_res[i*LANE_W +: LANE_W] = a_lane[i] ^ b_lane[i];
        OP_MIN:  alu_res[i*LANE_W +: LANE_W] = (a_lane[i] < b_lane[i]) ? a_lane[i] : b_lane[i];
        default: alu_res[i*LANE_W +: LANE_W] = a_lane[i];
      endcase
    end
  end

  // One shift-add step per lane; the last step's sum is the product itself,
  // so it is registered straight into the result without an extra cycle
  always_comb begin
    prod = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      acc_nxt[i] = acc_q[i] + (mplier_q[i][0] ? mcand_q[i] : '0);
      prod[i*LANE_W +: LANE_W] = acc_nxt[i];
    end
  end

  // Pick the result being registered this cycle and flag its zero lanes
  always_comb begin
    res_sel = mul_done ? prod : alu_res;
    lz_d    = '0;
    for (int unsigned i = 0; i < LANES; i++)
      lz_d[i] = (res_sel[i*LANE_W +: LANE_W] == '0);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = is_mul ? S_MUL : S_FULL;
      S_MUL:   if (mul_done) state_d = S_FULL;
      S_FULL:  if (bus.out_ready) state_d = accept ? (is_mul ? S_MUL : S_FULL) : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result registers: loaded on a non-mul accept or at multiply completion
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_q <= '0;
      lz_q      <= '1;
      zf_q      <= 1'b1;
      add8_q    <= '0;
    end else if ((accept && !is_mul) || mul_done) begin
      alu_out_q <= res_sel;
      lz_q      <= lz_d;
      zf_q      <= &lz_d;
      add8_q    <= mul_done ? add8_pend_q : br_sum;
    end
  end

  // Multiply sequencer: operands loaded on accept, one bit consumed per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      add8_pend_q <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        acc_q[i]    <= '0;
        mcand_q[i]  <= '0;
        mplier_q[i] <= '0;
      end
    end else if (accept && is_mul) begin
      cnt_q       <= CNT_W'(LANE_W);
      add8_pend_q <= br_sum;
      for (int unsigned i = 0; i < LANES; i++) begin
        acc_q[i]    <= '0;
        mcand_q[i]  <= a_lane[i];
        mplier_q[i] <= b_lane[i];
      end
    end else if (state_q == S_MUL) begin
      cnt_q <= cnt_q - CNT_W'(1);
      for (int unsigned i = 0; i < LANES; i++) begin
        acc_q[i]    <= acc_nxt[i];
        mcand_q[i]  <= mcand_q[i] << 1;
        mplier_q[i] <= mplier_q[i] >> 1;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == S_FULL);
  assign bus.alu_out   = alu_out_q;
  assign bus.add_8_out = add8_q;
  assign bus.lane_zero = lz_q;
  assign bus.zero_flag = zf_q;
endmodule

// File: tb/tb_execute_simd.sv
// Scoreboard bench for execute_simd: directed cases plus randomized traffic
// against a plain-arithmetic lane model.
module tb_execute_simd;
  localparam int unsigned LANES  = 8;
  localparam int unsigned LANE_W = 16;
  localparam int unsigned PC_W   = 15;
  localparam int unsigned W      = LANES * LANE_W;

  typedef struct packed {
    logic [W-1:0]     alu;
    logic [PC_W-1:0]  add8;
    logic [LANES-1:0] lz;
    logic             zf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_simd_if #(.LANES(LANES), .LANE_W(LANE_W), .PC_W(PC_W)) bus ();

  execute_simd #(.LANES(LANES), .LANE_W(LANE_W), .PC_W(PC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb[$];
  int unsigned passed  = 0;
  int unsigned total   = 0;
  int unsigned or_mode = 0;  // 0: ready high, 1: random, 2: ready low

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, input logic add1, input logic mem,
                                 input logic [PC_W-1:0] pc, input logic [PC_W-1:0] br);
    exp_t e;
    longint unsigned x, y, r, m;
    m = 64'd1 << LANE_W;
    e = '0;
    for (int i = 0; i < LANES; i++) begin
      x = a[i*LANE_W +: LANE_W];
      if (mem)       y = 0;
      else if (add1) y = 1;
      else           y = b[i*LANE_W +: LANE_W];
      case (op)
        3'd0:    r = (x + y) % m;
        3'd1:    r = (x + m - y) % m;
        3'd2:    r = x & y;
        3'd3:    r = x | y;
        3'd4:    r = x ^ y;
        3'd5:    r = (x * y) % m;
        3'd6:    r = (x < y) ? x : y;
        default: r = x;
      endcase
      e.alu[i*LANE_W +: LANE_W] = LANE_W'(r);
      e.lz[i] = (r == 0);
    end
    e.zf   = (e.lz == '1);
    e.add8 = PC_W'((longint'(pc) + longint'(br)) % (64'd1 << PC_W));
    return e;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 4))
        0:       v[i*LANE_W +: LANE_W] = '0;
        1:       v[i*LANE_W +: LANE_W] = '1;
        default: v[i*LANE_W +: LANE_W] = LANE_W'($urandom);
      endcase
    end
    return v;
  endfunction

  // Present one op, wait (bounded) for acceptance, record its expected result
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                      input logic add1, input logic mem,
                      input logic [PC_W-1:0] pc, input logic [PC_W-1:0] br,
                      output int unsigned waited);
    waited = 0;
    @(negedge clk);
    bus.rd1 = a; bus.rd2 = b; bus.alu_control = op;
    bus.add1_sel = add1; bus.mem_sel = mem; bus.pc_8 = pc; bus.branch = br;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    total++;
    if (bus.in_ready) begin
      passed++;
      sb.push_back(model(a, b, op, add1, mem, pc, br));
    end else begin
      $display("FAIL accept_timeout: got in_ready=0, expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Downstream ready driver
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (or_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every consumed result is compared against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_result: got %0h, expected no result", bus.alu_out);
        end else begin
          e = sb.pop_front();
          check("sb_alu_out", bus.alu_out, e.alu);
          check("sb_add_8_out", W'(bus.add_8_out), W'(e.add8));
          check("sb_lane_zero", W'(bus.lane_zero), W'(e.lz));
          check("sb_zero_flag", W'(bus.zero_flag), W'(e.zf));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned  wt, stall, cyc, seen, d;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    exp_t         e1, e2;

    bus.in_valid = 1'b0; bus.rd1 = '0; bus.rd2 = '0; bus.alu_control = '0;
    bus.add1_sel = 1'b0; bus.mem_sel = 1'b0; bus.pc_8 = '0; bus.branch = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #2;
    check("rst_out_valid", W'(bus.out_valid), W'(0));
    check("rst_alu_out", bus.alu_out, '0);
    check("rst_add_8_out", W'(bus.add_8_out), W'(0));
    check("rst_lane_zero", W'(bus.lane_zero), W'(8'hFF));
    check("rst_zero_flag", W'(bus.zero_flag), W'(1));
    check("rst_in_ready", W'(bus.in_ready), W'(1));

    // Wrapping add across all lanes, one-cycle latency
    send({LANES{16'hFFFF}}, {LANES{16'h0001}}, 3'b000, 1'b0, 1'b0, '0, '0, wt);
    @(negedge clk); #2;
    check("add_out_valid", W'(bus.out_valid), W'(1));
    check("add_alu_out", bus.alu_out, '0);
    check("add_lane_zero", W'(bus.lane_zero), W'(8'hFF));
    check("add_zero_flag", W'(bus.zero_flag), W'(1));

    // B-lane override priority
    a = W'(5);
    send(a, rand_vec(), 3'b001, 1'b1, 1'b1, '0, '0, wt);
    @(negedge clk); #2;
    check("sub_memsel_lane0", W'(bus.alu_out[LANE_W-1:0]), W'(5));
    send(a, rand_vec(), 3'b001, 1'b1, 1'b0, '0, '0, wt);
    @(negedge clk); #2;
    check("sub_add1_lane0", W'(bus.alu_out[LANE_W-1:0]), W'(4));

    // Multi-cycle multiply: stall length and latency
    a = W'(16'h0123) << (3 * LANE_W);
    b = W'(16'h0100) << (3 * LANE_W);
    send(a, b, 3'b101, 1'b0, 1'b0, '0, '0, wt);
    stall = 0; cyc = 0;
    while (cyc < 100) begin
      @(negedge clk); #1;
      if (bus.out_valid) break;
      if (!bus.in_ready) stall++;
      cyc++;
    end
    check("mul_out_valid", W'(bus.out_valid), W'(1));
    check("mul_latency", W'(cyc), W'(16));
    check("mul_stall_cycles", W'(stall), W'(16));
    check("mul_lane3", W'(bus.alu_out[3*LANE_W +: LANE_W]), W'(16'h2300));
    check("mul_lane_zero", W'(bus.lane_zero), W'(8'hF7));

    // Back-pressure: hold with out_ready low while a new op waits
    or_mode = 2;
    a = rand_vec(); b = rand_vec();
    e1 = model(a, b, 3'b100, 1'b0, 1'b0, 15'h1234, 15'h0042);
    send(a, b, 3'b100, 1'b0, 1'b0, 15'h1234, 15'h0042, wt);
    a = rand_vec(); b = rand_vec();
    e2 = model(a, b, 3'b110, 1'b0, 1'b0, 15'h0100, 15'h0001);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.rd1 = a; bus.rd2 = b; bus.alu_control = 3'b110;
      bus.add1_sel = 1'b0; bus.mem_sel = 1'b0; bus.pc_8 = 15'h0100; bus.branch = 15'h0001;
      bus.in_valid = 1'b1;
      #1;
      check("bp_in_ready", W'(bus.in_ready), W'(0));
      check("bp_out_valid", W'(bus.out_valid), W'(1));
      check("bp_alu_hold", bus.alu_out, e1.alu);
      check("bp_add8_hold", W'(bus.add_8_out), W'(e1.add8));
    end
    or_mode = 0;
    send(a, b, 3'b110, 1'b0, 1'b0, 15'h0100, 15'h0001, wt);
    check("bp_same_cycle_accept", W'(wt), W'(0));
    @(negedge clk); #2;
    check("bp_new_valid", W'(bus.out_valid), W'(1));
    check("bp_new_alu", bus.alu_out, e2.alu);

    // Branch adder wrap, aligned with its ALU result
    a = rand_vec(); b = rand_vec();
    e1 = model(a, b, 3'b011, 1'b0, 1'b0, 15'h7FF0, 15'h0020);
    send(a, b, 3'b011, 1'b0, 1'b0, 15'h7FF0, 15'h0020, wt);
    @(negedge clk); #2;
    check("branch_wrap", W'(bus.add_8_out), W'(15'h0010));
    check("branch_alu_aligned", bus.alu_out, e1.alu);

    // Reset in the middle of a multiply discards it
    send(rand_vec(), rand_vec(), 3'b101, 1'b0, 1'b0, '0, '0, wt);
    repeat (7) @(negedge clk);
    #1; rst = 1'b1; sb.delete();
    @(negedge clk); #1; rst = 1'b0;
    @(negedge clk); #2;
    check("abort_out_valid", W'(bus.out_valid), W'(0));
    check("abort_zero_flag", W'(bus.zero_flag), W'(1));
    check("abort_alu_out", bus.alu_out, '0);
    check("abort_in_ready", W'(bus.in_ready), W'(1));
    seen = 0;
    repeat (20) begin
      @(negedge clk); #2;
      if (bus.out_valid) seen++;
    end
    check("abort_no_result", W'(seen), W'(0));
    a = rand_vec(); b = rand_vec();
    send(a, b, 3'b000, 1'b0, 1'b0, PC_W'($urandom), PC_W'($urandom), wt);

    // Randomized traffic with random back-pressure
    or_mode = 1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
      op = 3'($urandom_range(0, 7));
      send(rand_vec(), rand_vec(), op, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           PC_W'($urandom), PC_W'($urandom), wt);
    end

    or_mode = 0;
    d = 0;
    while (sb.size() != 0 && d < 200) begin
      @(negedge clk);
      d++;
    end
    @(negedge clk); #3;
    check("drain_empty", W'(sb.size()), W'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/execute_simd.md
# execute_simd

Parametrised, pipelined execute stage for the vector datapath. It takes two packed register operands and applies one lane-wise ALU operation across `LANES` independent lanes of `LANE_W` bits, including an iterative multi-cycle multiply. It also computes the branch target. All results are registered behind a valid/ready handshake, so the stage can be stalled by the memory stage and can stall decode in turn.

## Interface
Parameters:
- `LANES`, 8, number of independent lanes.
- `LANE_W`, 16, bits per lane; packed operand width is `LANES*LANE_W`, lane i occupying bits [i*LANE_W +: LANE_W].
- `PC_W`, 15, width of PC and branch-offset fields.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation presented this cycle.
- `in_ready`  out  1  stage accepts an operation this cycle.
- `rd1`, `rd2`  in  `LANES*LANE_W`  operands A and B (packed).
- `alu_control`  in  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 mul, 110 unsigned min, 111 pass A.
- `add1_sel`  in  1  replace every B lane with 1.
- `mem_sel`  in  1  replace every B lane with 0; overrides `add1_sel`.
- `pc_8`, `branch`  in  `PC_W`  branch adder operands.
- `out_valid`  out  1  result registers hold a valid result.
- `out_ready`  in  1  downstream consumes the result this cycle.
- `alu_out`  out  `LANES*LANE_W`  packed result.
- `add_8_out`  out  `PC_W`  `(pc_8 + branch) mod 2^PC_W`, captured at accept.
- `lane_zero`  out  `LANES`  bit i set when result lane i equals 0.
- `zero_flag`  out  1  AND of all `lane_zero` bits.

## Operation
- Accept occurs when `in_valid && in_ready`. All inputs are sampled only on accept.
- B-operand select per lane:
  - `mem_sel` gives 0.
  - Otherwise `add1_sel` gives 1.
  - Otherwise the B lane comes from `rd2`.
- Lane arithmetic:
  - Results are modulo 2^`LANE_W`; there are no carries across lanes.
  - sub is A−B with wrap.
  - mul keeps the low `LANE_W` bits of A×B (unsigned).
  - min compares unsigned.
- State machine, states IDLE, MUL, FULL:
  - IDLE: no result held. `in_ready`=1. A non-mul accept goes to FULL with the result registered. A mul accept goes to MUL and loads the counter with `LANE_W`.
  - MUL: shift-add one multiplier bit per lane per cycle, all lanes in parallel. `in_ready`=0. The counter decrements each cycle; on the cycle it reaches 0, go to FULL with the product registered.
  - FULL: `out_valid`=1 and outputs are held stable until consumed.
    - `out_ready` low: hold.
    - `out_ready` high: the result is consumed. `in_ready` = `out_ready` in FULL, so a same-cycle accept is allowed. A non-mul accept stays in FULL with the new result; a mul accept goes to MUL. With no accept, go to IDLE.
- `add_8_out`, `lane_zero` and `zero_flag` are registered together with `alu_out` and always describe the same operation.

## Timing
- Reset (`rst` high at an edge):
  - State becomes IDLE; `out_valid`=0; `alu_out`=0; `add_8_out`=0; `lane_zero`=all ones; `zero_flag`=1; counter=0.
  - An in-flight mul is aborted and its result discarded.
  - `in_ready` is 1 in the cycle after reset deasserts.
- Non-mul latency: accept at edge N gives `out_valid` high after edge N (visible in cycle N+1).
- Mul latency: accept at edge N gives `out_valid` high after edge N+`LANE_W`.
- Throughput:
  - One non-mul op per cycle while `out_ready` stays high.
  - Mul ops occupy the stage for `LANE_W` cycles each.
- Back-pressure: while `out_valid && !out_ready`, outputs must not change and no operation is accepted.
- `in_ready` is combinational from state and `out_ready` only, never from `in_valid`.
- `in_valid` during MUL is ignored and is not lost upstream, because `in_ready`=0.

## Test plan
- Reset, then add with `LANES`=8, `LANE_W`=16, A lanes=0xFFFF, B lanes=0x0001 → one cycle later `out_valid`=1, all lanes 0x0000, `lane_zero`=0xFF, `zero_flag`=1.
- sub with `add1_sel`=1 and `mem_sel`=1, A lane0=5 → B forced to 0, lane0=5. Same with only `add1_sel`=1 → lane0=4.
- mul, A lane3=0x0123, B lane3=0x0100, other lanes 0 → `in_ready`=0 for 16 cycles, `out_valid` after edge N+16, lane3=0x2300, `lane_zero`=0xF7.
- Back-pressure: result held with `out_ready`=0 for 5 cycles while `in_valid`=1 → outputs stable, `in_ready`=0. Raise `out_ready` → next op accepted the same cycle, new result the next cycle.
- Branch: `pc_8`=0x7FF0, `branch`=0x0020 → `add_8_out`=0x0010 (wrap), aligned with its ALU result.
- Assert `rst` at cycle 7 of a mul → `out_valid`=0, `zero_flag`=1, no result emitted. A subsequent add completes normally.
